// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state type for the up/down index counters
package counter_pkg;

    typedef enum logic {
        eIDLE     = 1'b0,
        eCOUNTING = 1'b1
    } count_state_e;

    // True when a sequence of max_val+1 beats fits in a word of word_size bits
    function automatic bit max_fits(input int unsigned word_size, input int unsigned max_val);
        return (64'(max_val) >> word_size) == 64'd0;
    endfunction

endpackage

// File: rtl/down_counter_handshake.sv
// rtl/down_counter_handshake.sv - INPUT_MAX..0 index generator on a valid/ready handshake
// Optional build macro: DOWN_COUNTER_AUTO_RELOAD_EN (reload forever after each sequence).
module down_counter_handshake
    import counter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned INPUT_MAX = 10
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic                 ready_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 valid_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [WORD_SIZE-1:0] MAX_VAL = WORD_SIZE'(INPUT_MAX);
    localparam logic [WORD_SIZE-1:0] ONE     = WORD_SIZE'(1);

    if (!max_fits(WORD_SIZE, INPUT_MAX)) begin : g_bad_input_max
        $error("INPUT_MAX does not fit in WORD_SIZE bits");
    end

    count_state_e         state_q, ns;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 done_q;
    logic                 fire;
    logic                 final_fire;

    // valid_o is the state itself: in eCOUNTING there is always a beat on offer
    assign valid_o = (state_q == eCOUNTING);
    assign busy_o  = (state_q == eCOUNTING);
    assign last_o  = valid_o && (data_q == '0);
    assign data_o  = data_q;
    assign done_o  = done_q;

    always_comb begin
        ns         = state_q;
        data_d     = data_q;
        fire       = valid_o && ready_i;
        final_fire = fire && (data_q == '0);
        unique case (state_q)
            eIDLE: begin
                if (start_i) begin
                    ns     = eCOUNTING;
                    data_d = MAX_VAL;
                end else begin
                    data_d = '0;
                end
            end
            eCOUNTING: begin
                if (fire) begin
                    if (data_q != '0) begin
                        data_d = data_q - ONE;
                    end else begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                        data_d = MAX_VAL;
`else
                        // start_i on the final beat restarts with no bubble
                        if (start_i) begin
                            data_d = MAX_VAL;
                        end else begin
                            ns     = eIDLE;
                            data_d = '0;
                        end
`endif
                    end
                end
            end
            default: begin
                ns     = eIDLE;
                data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= eIDLE;
        end else begin
            state_q <= ns;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= final_fire;
        end
    end

endmodule
